// File: rtl/uart_char_rx.sv
// Purpose : 8N1 UART receiver; emits an ASCII byte on `char` with a one-cycle `shift` strobe
//           for the typewriter stage, or a one-cycle `frame_err` pulse on a bad frame.
// Latency : shift/char update 1 cycle after the mid-stop-bit sample; start edge seen 2 cycles after the pin.
// Backpressure: none; downstream must accept every `shift` (minimum spacing ~9.5 bit times).
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   rx         asynchronous serial input, idle high
//   char       last correctly received byte, held between frames
//   shift      one-cycle pulse when char updates
//   frame_err  one-cycle pulse on a bad frame (char unchanged)
//   busy       high whenever the receiver is not idle
//
// Build option: define UART_CHAR_RX_PARITY_EN for 8E1 (even parity bit between data and stop).
module uart_char_rx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  RESET_CHAR   = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] char,
  output logic       shift,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_CHAR_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state, state_n;
  logic        rx_m, rx_s, rx_d;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        take_bit;
  logic        fin_ok;
  logic        fin_err;
`ifdef UART_CHAR_RX_PARITY_EN
  logic        par_take;
  logic        par_bad;
`endif

  always_comb begin
    state_n  = state;
    take_bit = 1'b0;
    fin_ok   = 1'b0;
    fin_err  = 1'b0;
`ifdef UART_CHAR_RX_PARITY_EN
    par_take = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Needs a real 1->0 transition, so a held break never starts a frame.
        if (rx_d && !rx_s) state_n = START;
      end
      START: begin
        // Mid-start-bit recheck rejects short glitches silently.
        if (bit_cnt == HALF_CNT) state_n = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (bit_cnt == FULL_CNT) begin
          take_bit = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_CHAR_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_CHAR_RX_PARITY_EN
      PARITY: begin
        if (bit_cnt == FULL_CNT) begin
          par_take = 1'b1;
          state_n  = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at mid-stop-bit so a following start edge with no gap is still caught.
        if (bit_cnt == FULL_CNT) begin
          state_n = IDLE;
`ifdef UART_CHAR_RX_PARITY_EN
          if (rx_s && !par_bad) fin_ok = 1'b1;
          else                  fin_err = 1'b1;
`else
          if (rx_s) fin_ok = 1'b1;
          else      fin_err = 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_d      <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      char      <= RESET_CHAR;
      shift     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_CHAR_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      rx_m  <= rx;
      rx_s  <= rx_m;
      rx_d  <= rx_s;
      state <= state_n;
      // Counter restarts on each state change and at each data-bit boundary.
      if (state_n != state || take_bit) bit_cnt <= 16'd0;
      else                              bit_cnt <= bit_cnt + 16'd1;
      if (state == IDLE) begin
        bit_idx <= 3'd0;
      end else if (take_bit) begin
        shreg   <= {rx_s, shreg[7:1]};  // LSB arrives first
        bit_idx <= bit_idx + 3'd1;
      end
`ifdef UART_CHAR_RX_PARITY_EN
      if (state == IDLE)  par_bad <= 1'b0;
      else if (par_take)  par_bad <= ^{shreg, rx_s};  // even parity over data + parity bit
`endif
      shift     <= fin_ok;
      frame_err <= fin_err;
      if (fin_ok) char <= shreg;
    end
  end

  assign busy = (state != IDLE);

endmodule
